cla_sum_stage: RTL
==================

# cla_sum_stage

Pipelined sum-generation stage of the Wallace multiplier's final carry-lookahead adder, directly downstream of the parallel-prefix carry network (`ppc`). It takes the two operand rows, the carry-in, and the resolved per-bit carry status vector ("k"/"p"/"g" ASCII characters) from the prefix network. It decodes the status into bit carries and forms the N-bit sum plus carry-out. Results are delivered through a 2-stage valid/ready pipeline to the product register.

## Interface
- `N`, default 64: operand width; must match the prefix network width.
- `CNT_W`, default 16: width of the illegal-status counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  stage can accept the input word this cycle
- `in_a`  in  N  operand row A
- `in_b`  in  N  operand row B
- `in_cin`  in  1  adder carry-in
- `in_status`  in  N×8 (`[N-1:0][7:0]`)  prefix status per bit, ASCII "k"=8'h6B, "p"=8'h70, "g"=8'h67
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_sum`  out  N  A + B + cin, low N bits
- `out_cout`  out  1  carry out of bit N-1
- `out_err`  out  1  word contained ≥1 illegal status character
- `err_cnt`  out  CNT_W  count of accepted words with `out_err`, saturating

## Operation
- Carry into bit 0 is `in_cin`.
- Carry into bit i (i≥1) is taken from `in_status[i-1]`: "g" gives 1, "k" gives 0, "p" gives `in_cin` (a chain that propagates all the way down to bit 0).
- `out_cout` is taken from `in_status[N-1]` by the same rule.
- `sum[i] = a[i] ^ b[i] ^ c[i]`.
- Any status byte that is not k/p/g is illegal:
  - it decodes to carry 0;
  - the word's `out_err` is 1.
- Stage 1 (S1) registers `a^b`, the decoded carry vector, the cout, and the err flag.
- Stage 2 (S2) registers the sum, cout and err onto the outputs.
- `err_cnt` increments by 1 when a word with err=1 moves S1→S2. It holds at 2^CNT_W−1.
- Handshake:
  - input transfer occurs when `in_valid && in_ready`;
  - output transfer occurs when `out_valid && out_ready`;
  - `in_valid` may not be withdrawn, and input data may not change, until the transfer occurs;
  - `out_valid` and the output data are held stable until the transfer occurs.

## Timing
- Latency is 2 cycles: a word accepted at edge k is presented on `out_*` after edge k+2, assuming no stall.
- Throughput is 1 word/cycle when `out_ready` is held high.
- Stall logic:
  - `adv2 = !out_valid || out_ready`
  - `adv1 = !s1_valid || adv2`
  - `in_ready = adv1`, which is combinational from `out_ready`. No input-to-output combinational path exists other than this.
- With `out_ready` low and both stages full, `in_ready` is 0 and all registers hold their values.
- Simultaneous accept and deliver on a full pipe: both transfers occur in the same cycle and no bubble is inserted.
- Reset (`rst_n` low at an edge) clears S1/S2 valid and `out_valid`, and zeroes `out_sum`, `out_cout`, `out_err` and `err_cnt`.
  - Words in flight are discarded.
  - `in_ready` is 1 in the first cycle after reset is released.
  - A reset asserted mid-stall drops the held result and does not count it.

## Structure
- Package `cla_pkg`:
  - localparams `CH_K=8'h6B`, `CH_P=8'h70`, `CH_G=8'h67`;
  - `N_DEF=64`;
  - typedef `status_t` = `logic [7:0]`.
- The prefix network and the upstream k/p/g encoder share the same package.
- Sub-module `cla_carry_decode` is purely combinational and per-bit: status byte + cin → carry, illegal. It is instantiated N times in S1 via `generate`.
- The top level contains the two pipeline register stages, the handshake logic and the saturating counter.

## Test plan
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, status all "g", `out_ready`=1: sum=0, cout=1, err=0, and `out_valid` rises exactly 2 cycles after the accept.
- a=5, b=3, cin=0, status[0]="g", status[1]="g", status[2]="g", status[63:3]="k": sum=8, cout=0.
- a=64'hAAAA…AAAA, b=64'h5555…5555, cin=1, status all "p": sum=0, cout=1. Repeat with cin=0: sum=64'hFFFF…FFFF, cout=0.
- Illegal byte: status[10]=8'h78 ("x"), all others "k", a=b=0: sum=0, err=1, err_cnt goes 0→1. Preload the counter at 16'hFFFF, repeat the word, and err_cnt stays 16'hFFFF.
- Back-pressure:
  - stream 4 words with `out_ready` low;
  - `in_ready` drops after 2 accepts, and outputs hold word 0;
  - raise `out_ready` and observe words 0–3 in order, none lost or duplicated, then a continuous 1 word/cycle stream.
- Pull `rst_n` low for 1 cycle while 2 words are in flight: `out_valid`=0, err_cnt=0, `in_ready`=1 next cycle, and no stale word emerges afterward.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the final carry-lookahead adder of the
// Wallace multiplier (k/p/g encoder, prefix network, sum stage).
//   CH_K/CH_P/CH_G : ASCII carry-status characters kill/propagate/generate
//   N_DEF          : default operand width
//   status_t       : one per-bit status byte
package cla_pkg;

   localparam logic [7:0] CH_K  = 8'h6B;  // "k"
   localparam logic [7:0] CH_P  = 8'h70;  // "p"
   localparam logic [7:0] CH_G  = 8'h67;  // "g"
   localparam int         N_DEF = 64;

   typedef logic [7:0] status_t;

   // True when a status byte is one of the three legal characters.
   function automatic logic status_legal(input status_t s);
      return (s == CH_K) || (s == CH_P) || (s == CH_G);
   endfunction

endpackage

// File: rtl/cla_carry_decode.sv
// cla_carry_decode: per-bit combinational decode of a resolved prefix status.
//   status_i  : status byte for the carry out of this bit position
//   cin_i     : adder carry-in (value of a chain that propagates to bit 0)
//   carry_o   : decoded carry (0 for an illegal byte)
//   illegal_o : status byte is not k/p/g
module cla_carry_decode
   import cla_pkg::*;
(
   input  status_t status_i,
   input  logic    cin_i,
   output logic    carry_o,
   output logic    illegal_o
);

   always_comb begin
      carry_o   = 1'b0;
      illegal_o = !status_legal(status_i);
      case (status_i)
         CH_G:    carry_o = 1'b1;
         CH_P:    carry_o = cin_i;
         default: carry_o = 1'b0;  // "k" and any illegal byte
      endcase
   end

endmodule

// File: rtl/cla_sum_stage.sv
// cla_sum_stage: two-stage valid/ready pipeline forming A + B + cin from the
// operand rows and the per-bit carry status resolved by the prefix network.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_a, in_b, in_cin   : operand rows and carry-in
//   in_status            : per-bit status byte ("k"/"p"/"g")
//   out_valid/out_ready  : output handshake
//   out_sum, out_cout    : low N bits of the sum and carry out of bit N-1
//   out_err              : word carried at least one illegal status byte
//   err_cnt              : saturating count of erroneous words entering S2
module cla_sum_stage
   import cla_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_a,
   input  logic [N-1:0]         in_b,
   input  logic                 in_cin,
   input  status_t [N-1:0]      in_status,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_sum,
   output logic                 out_cout,
   output logic                 out_err,
   output logic [CNT_W-1:0]     err_cnt
);

   // ---------------------------------------------------------------------
   // Carry decode: status[i] describes the carry out of bit i, so it feeds
   // the carry into bit i+1; bit 0 takes the carry-in directly.
   // ---------------------------------------------------------------------
   logic [N-1:0] dec_carry;
   logic [N-1:0] dec_ill;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dec
         cla_carry_decode u_dec (
            .status_i  (in_status[gi]),
            .cin_i     (in_cin),
            .carry_o   (dec_carry[gi]),
            .illegal_o (dec_ill[gi])
         );
      end
   endgenerate

   logic [N-1:0] carry_vec;
   assign carry_vec = {dec_carry[N-2:0], in_cin};

   // ---------------------------------------------------------------------
   // Pipeline state
   // ---------------------------------------------------------------------
   logic             s1_vld_q,   s1_vld_d;
   logic [N-1:0]     s1_axb_q,   s1_axb_d;
   logic [N-1:0]     s1_carry_q, s1_carry_d;
   logic             s1_cout_q,  s1_cout_d;
   logic             s1_err_q,   s1_err_d;

   logic             out_vld_q,  out_vld_d;
   logic [N-1:0]     sum_q,      sum_d;
   logic             cout_q,     cout_d;
   logic             err_q,      err_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   // A stage may load when it is empty or its content leaves this cycle.
   logic adv1, adv2;
   assign adv2     = !out_vld_q || out_ready;
   assign adv1     = !s1_vld_q || adv2;
   assign in_ready = adv1;

   always_comb begin
      s1_vld_d   = s1_vld_q;
      s1_axb_d   = s1_axb_q;
      s1_carry_d = s1_carry_q;
      s1_cout_d  = s1_cout_q;
      s1_err_d   = s1_err_q;
      out_vld_d  = out_vld_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      err_d      = err_q;
      cnt_d      = cnt_q;

      if (adv1) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_axb_d   = in_a ^ in_b;
            s1_carry_d = carry_vec;
            s1_cout_d  = dec_carry[N-1];
            s1_err_d   = |dec_ill;
         end
      end

      if (adv2) begin
         out_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            sum_d  = s1_axb_q ^ s1_carry_q;
            cout_d = s1_cout_q;
            err_d  = s1_err_q;
            // Count on the S1->S2 move, holding at all-ones.
            if (s1_err_q && (cnt_q != {CNT_W{1'b1}}))
               cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_axb_q   <= '0;
         s1_carry_q <= '0;
         s1_cout_q  <= 1'b0;
         s1_err_q   <= 1'b0;
         out_vld_q  <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_axb_q   <= s1_axb_d;
         s1_carry_q <= s1_carry_d;
         s1_cout_q  <= s1_cout_d;
         s1_err_q   <= s1_err_d;
         out_vld_q  <= out_vld_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid = out_vld_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_err   = err_q;
   assign err_cnt   = cnt_q;

endmodule
